// File: rtl/pipeline_hazard_controller.sv
// Hazard-aware sequencing for the 5-stage pipeline: stalls, flushes, RAM waits and post-reset init.
// Optional macro HAZARD_PERF_COUNTER_EN adds cycle/stall/flush performance counters.
module pipeline_hazard_controller #(
  parameter int unsigned INIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [4:0]  id_rs1_address,
  input  logic [4:0]  id_rs2_address,
  input  logic        id_uses_rs1,
  input  logic        id_uses_rs2,
  input  logic [4:0]  ex_rd_address,
  input  logic [4:0]  mem_rd_address,
  input  logic [4:0]  wb_rd_address,
  input  logic        ex_reg_wren,
  input  logic        mem_reg_wren,
  input  logic        wb_reg_wren,
  input  logic        mem_ram_access,
  input  logic        mem_ram_wren,
  input  logic        mem_redirect,
  input  logic        ram_ack,
  output logic        stage_reset_n,
  output logic        pc_wren,
  output logic        if_id_wren,
  output logic        id_ex_wren,
  output logic        ex_mem_wren,
  output logic        mem_wb_wren,
  output logic        if_id_bubble,
  output logic        id_ex_bubble,
  output logic        ex_mem_bubble,
  output logic        mem_wb_bubble,
  output logic        pc_redirect,
  output logic        ram_req,
  output logic        ram_wren,
`ifdef HAZARD_PERF_COUNTER_EN
  output logic [31:0] perf_cycle_count,
  output logic [31:0] perf_stall_count,
  output logic [31:0] perf_flush_count,
`endif
  output logic        reg_wren
);

  typedef enum logic [1:0] {INIT, RUN, MEM_WAIT} state_t;

  state_t     state, state_next;
  logic [3:0] init_count;
  logic       raw_hazard;
  logic       hold;
  logic       advance;

  // WB participates because the register file has no write-through path.
  function automatic logic src_hazard(input logic [4:0] addr, input logic used);
    return used && (addr != 5'd0) &&
           ((ex_reg_wren  && (addr == ex_rd_address))  ||
            (mem_reg_wren && (addr == mem_rd_address)) ||
            (wb_reg_wren  && (addr == wb_rd_address)));
  endfunction

  assign raw_hazard = src_hazard(id_rs1_address, id_uses_rs1) ||
                      src_hazard(id_rs2_address, id_uses_rs2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= INIT;
      init_count <= 4'(INIT_CYCLES);
    end else begin
      state <= state_next;
      if (state == INIT && init_count != 4'd0)
        init_count <= init_count - 4'd1;
    end
  end

  always_comb begin
    state_next    = state;
    stage_reset_n = 1'b1;
    hold          = 1'b0;
    advance       = 1'b0;
    ram_req       = 1'b0;
    pc_wren       = 1'b0;
    if_id_wren    = 1'b0;
    id_ex_wren    = 1'b0;
    ex_mem_wren   = 1'b0;
    mem_wb_wren   = 1'b0;
    if_id_bubble  = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    pc_redirect   = 1'b0;

    unique case (state)
      INIT: begin
        stage_reset_n = 1'b0;
        if (init_count <= 4'd1)
          state_next = RUN;
      end
      RUN: begin
        ram_req = mem_ram_access;
        if (mem_ram_access && !ram_ack) begin
          hold       = 1'b1;
          state_next = MEM_WAIT;
        end else begin
          advance = 1'b1;
        end
      end
      MEM_WAIT: begin
        ram_req = 1'b1;
        if (ram_ack) begin
          advance    = 1'b1;
          state_next = RUN;
        end else begin
          hold = 1'b1;
        end
      end
      default: state_next = INIT;
    endcase

    // A RAM wait drains only the MEM/WB register; redirect outranks RAW since ID is squashed.
    if (hold) begin
      mem_wb_wren   = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (advance) begin
      ex_mem_wren = 1'b1;
      mem_wb_wren = 1'b1;
      id_ex_wren  = 1'b1;
      if (mem_redirect) begin
        pc_wren       = 1'b1;
        if_id_wren    = 1'b1;
        pc_redirect   = 1'b1;
        if_id_bubble  = 1'b1;
        id_ex_bubble  = 1'b1;
        ex_mem_bubble = 1'b1;
      end else if (raw_hazard) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_wren    = 1'b1;
        if_id_wren = 1'b1;
      end
    end
  end

  assign ram_wren = ram_req & ram_ack & mem_ram_wren;
  assign reg_wren = wb_reg_wren & (state != INIT);

`ifdef HAZARD_PERF_COUNTER_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_cycle_count <= 32'd0;
      perf_stall_count <= 32'd0;
      perf_flush_count <= 32'd0;
    end else begin
      if (state != INIT)
        perf_cycle_count <= perf_cycle_count + 32'd1;
      if (state != INIT && !pc_wren)
        perf_stall_count <= perf_stall_count + 32'd1;
      if (pc_redirect)
        perf_flush_count <= perf_flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed vectors push expected outputs, a monitor compares.
// Build with HAZARD_PERF_COUNTER_EN defined to also exercise the performance counters.
module tb_pipeline_hazard_controller;

  typedef struct packed {
    logic       rst_n;
    logic [4:0] rs1, rs2;
    logic       u1, u2;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_w, mem_w, wb_w;
    logic       acc, st, redir, ack;
  } stim_t;

  typedef struct {
    logic [13:0] v;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  logic [4:0] id_rs1_address = '0, id_rs2_address = '0;
  logic id_uses_rs1 = 0, id_uses_rs2 = 0;
  logic [4:0] ex_rd_address = '0, mem_rd_address = '0, wb_rd_address = '0;
  logic ex_reg_wren = 0, mem_reg_wren = 0, wb_reg_wren = 0;
  logic mem_ram_access = 0, mem_ram_wren = 0, mem_redirect = 0, ram_ack = 0;
  logic stage_reset_n, pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren;
  logic if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble;
  logic pc_redirect, ram_req, ram_wren, reg_wren;
`ifdef HAZARD_PERF_COUNTER_EN
  logic [31:0] perf_cycle_count, perf_stall_count, perf_flush_count;
`endif

  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  exp_t mon_e;

  pipeline_hazard_controller #(.INIT_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1_address(id_rs1_address), .id_rs2_address(id_rs2_address),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd_address(ex_rd_address), .mem_rd_address(mem_rd_address), .wb_rd_address(wb_rd_address),
    .ex_reg_wren(ex_reg_wren), .mem_reg_wren(mem_reg_wren), .wb_reg_wren(wb_reg_wren),
    .mem_ram_access(mem_ram_access), .mem_ram_wren(mem_ram_wren),
    .mem_redirect(mem_redirect), .ram_ack(ram_ack),
    .stage_reset_n(stage_reset_n), .pc_wren(pc_wren), .if_id_wren(if_id_wren),
    .id_ex_wren(id_ex_wren), .ex_mem_wren(ex_mem_wren), .mem_wb_wren(mem_wb_wren),
    .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble),
    .ex_mem_bubble(ex_mem_bubble), .mem_wb_bubble(mem_wb_bubble),
    .pc_redirect(pc_redirect), .ram_req(ram_req), .ram_wren(ram_wren),
`ifdef HAZARD_PERF_COUNTER_EN
    .perf_cycle_count(perf_cycle_count), .perf_stall_count(perf_stall_count),
    .perf_flush_count(perf_flush_count),
`endif
    .reg_wren(reg_wren)
  );

  always #5 clk = ~clk;

  // Expected-vector layout: {stage_reset_n, 5 enables (pc..mem_wb), 4 bubbles, pc_redirect, ram_req, ram_wren, reg_wren}
  function automatic logic [13:0] mk(input logic srn, input logic [4:0] en, input logic [3:0] bub,
                                     input logic redir, input logic req, input logic rw, input logic regw);
    return {srn, en, bub, redir, req, rw, regw};
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic applyStimulus(input stim_t s, input logic [13:0] expv, input string name);
    exp_t e;
    @(posedge clk);
    #1;
    reset_n        = s.rst_n;
    id_rs1_address = s.rs1;
    id_rs2_address = s.rs2;
    id_uses_rs1    = s.u1;
    id_uses_rs2    = s.u2;
    ex_rd_address  = s.ex_rd;
    mem_rd_address = s.mem_rd;
    wb_rd_address  = s.wb_rd;
    ex_reg_wren    = s.ex_w;
    mem_reg_wren   = s.mem_w;
    wb_reg_wren    = s.wb_w;
    mem_ram_access = s.acc;
    mem_ram_wren   = s.st;
    mem_redirect   = s.redir;
    ram_ack        = s.ack;
    e.v    = expv;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    logic [13:0] got;
    got = {stage_reset_n, pc_wren, if_id_wren, id_ex_wren, ex_mem_wren, mem_wb_wren,
           if_id_bubble, id_ex_bubble, ex_mem_bubble, mem_wb_bubble,
           pc_redirect, ram_req, ram_wren, reg_wren};
    checks++;
    if (got !== e.v) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b", e.name, got, e.v);
    end
  endtask

  task automatic checkCount(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        checkOutput(mon_e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, %0d expectations pending", sb.size());
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    logic [13:0] init_v, norm, stall, hold, redir;
    logic [13:0] req_b, rw_b, rgw_b;
    init_v = mk(1'b0, 5'b00000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    norm   = mk(1'b1, 5'b11111, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    stall  = mk(1'b1, 5'b00111, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0);
    hold   = mk(1'b1, 5'b00001, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
    redir  = mk(1'b1, 5'b11111, 4'b1110, 1'b1, 1'b0, 1'b0, 1'b0);
    req_b  = 14'b100;
    rw_b   = 14'b010;
    rgw_b  = 14'b001;

    #1 reset_n = 1'b0;

    // Reset and init sequence
    s = idle(); s.rst_n = 1'b0;
    applyStimulus(s, init_v, "reset_state");
    s = idle();
    applyStimulus(s, init_v, "init_cycle1");
    applyStimulus(s, init_v, "init_cycle2");
    applyStimulus(s, norm, "first_run");

    // RAW on x5 as the producer walks EX -> MEM -> WB
    s = idle(); s.rs1 = 5'd5; s.u1 = 1'b1; s.ex_rd = 5'd5; s.ex_w = 1'b1;
    applyStimulus(s, stall, "raw_ex");
    s = idle(); s.rs1 = 5'd5; s.u1 = 1'b1; s.mem_rd = 5'd5; s.mem_w = 1'b1;
    applyStimulus(s, stall, "raw_mem");
    s = idle(); s.rs1 = 5'd5; s.u1 = 1'b1; s.wb_rd = 5'd5; s.wb_w = 1'b1;
    applyStimulus(s, stall | rgw_b, "raw_wb");
    s = idle(); s.rs1 = 5'd5; s.u1 = 1'b1;
    applyStimulus(s, norm, "raw_clear");
    s = idle(); s.rs1 = 5'd0; s.u1 = 1'b1; s.ex_rd = 5'd0; s.ex_w = 1'b1;
    applyStimulus(s, norm, "raw_x0");
    s = idle(); s.rs2 = 5'd9; s.u2 = 1'b0; s.ex_rd = 5'd9; s.ex_w = 1'b1;
    applyStimulus(s, norm, "raw_unused_src");
    s = idle(); s.rs2 = 5'd9; s.u2 = 1'b1; s.mem_rd = 5'd9; s.mem_w = 1'b0;
    applyStimulus(s, norm, "raw_no_wren");
    s = idle(); s.rs2 = 5'd9; s.u2 = 1'b1; s.mem_rd = 5'd9; s.mem_w = 1'b1;
    applyStimulus(s, stall, "raw_rs2_mem");

    // Store with ack delayed by 3 cycles
    s = idle(); s.acc = 1'b1; s.st = 1'b1;
    applyStimulus(s, hold, "store_wait0");
    applyStimulus(s, hold, "store_wait1");
    applyStimulus(s, hold, "store_wait2");
    s.ack = 1'b1;
    applyStimulus(s, norm | req_b | rw_b, "store_ack");
    s = idle();
    applyStimulus(s, norm, "store_done");

    // Zero-wait load
    s = idle(); s.acc = 1'b1; s.ack = 1'b1;
    applyStimulus(s, norm | req_b, "load_zero_wait");

    // Redirect masks a simultaneous RAW
    s = idle(); s.redir = 1'b1; s.rs1 = 5'd5; s.u1 = 1'b1; s.ex_rd = 5'd5; s.ex_w = 1'b1;
    applyStimulus(s, redir, "redirect_over_raw");
    s = idle();
    applyStimulus(s, norm, "after_redirect");

    // Redirect held off by a RAM wait, applied on the ack cycle
    s = idle(); s.acc = 1'b1; s.redir = 1'b1;
    applyStimulus(s, hold, "wait_redirect0");
    applyStimulus(s, hold, "wait_redirect1");
    s.ack = 1'b1;
    applyStimulus(s, redir | req_b, "wait_redirect_ack");

    // Reset asserted mid-wait drops the request immediately and ignores the ack
    s = idle(); s.acc = 1'b1; s.st = 1'b1;
    applyStimulus(s, hold, "wait_again0");
    applyStimulus(s, hold, "wait_again1");
    s.rst_n = 1'b0; s.ack = 1'b1; s.wb_w = 1'b1;
    applyStimulus(s, init_v, "reset_mid_wait");
    s = idle(); s.wb_w = 1'b1;
    applyStimulus(s, init_v, "reinit1_regw_masked");
    s = idle();
    applyStimulus(s, init_v, "reinit2");
    applyStimulus(s, norm, "rerun");

`ifdef HAZARD_PERF_COUNTER_EN
    s = idle(); s.rst_n = 1'b0;
    applyStimulus(s, init_v, "perf_reset");
    s = idle();
    applyStimulus(s, init_v, "perf_init1");
    applyStimulus(s, init_v, "perf_init2");
    applyStimulus(s, norm, "perf_run1");
    s.redir = 1'b1;
    applyStimulus(s, redir, "perf_redirect");
    s = idle(); s.rs1 = 5'd7; s.u1 = 1'b1; s.ex_rd = 5'd7; s.ex_w = 1'b1;
    applyStimulus(s, stall, "perf_stall1");
    s = idle(); s.rs1 = 5'd7; s.u1 = 1'b1; s.mem_rd = 5'd7; s.mem_w = 1'b1;
    applyStimulus(s, stall, "perf_stall2");
    s = idle();
    for (int i = 0; i < 6; i++)
      applyStimulus(s, norm, "perf_run_tail");
    @(posedge clk);
    #1;
    checkCount("perf_cycle_count", perf_cycle_count, 32'd10);
    checkCount("perf_stall_count", perf_stall_count, 32'd2);
    checkCount("perf_flush_count", perf_flush_count, 32'd1);
`endif

    for (int i = 0; i < 20 && sb.size() > 0; i++)
      @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
